fp_operand_sequencer: RTL and testbench

Parametrised successor to the top-level operand-entry path of the FP subtraction practice. It collects `N_OPS` operands of `WIDTH` bits one byte per button press from the switches. It then launches the FP ALU through a start/done handshake, with a timeout, and latches the result. It also produces the 24-bit display word, paging the result 16 bits at a time. It sits between the board inputs (already inverted to active-high) and the FPALU/DISPLAYS instances.

---
 rtl/fp_operand_sequencer_pkg.sv | 16 +
 rtl/fp_operand_sequencer_btn_edge_sync.sv | 33 +++
 rtl/fp_operand_sequencer.sv | 154 +++++++++++++++
 tb/tb_fp_operand_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_operand_sequencer_pkg.sv
// Shared types and display constants for the FP operand sequencer.
package fp_seq_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        CALC  = 2'd1,
        SHOW  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [7:0] ST_CALC    = 8'hCC;
    localparam logic [7:0] ST_ERR     = 8'hEE;
    localparam logic [3:0] ST_SHOW_HI = 4'h5;
    localparam logic [3:0] ST_OP_BASE = 4'hA;

endpackage

// File: rtl/fp_operand_sequencer_btn_edge_sync.sv
// Two-flop synchroniser for the push button with a one-cycle rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/fp_operand_sequencer.sv
// Operand entry FSM: byte-wise operand capture, ALU start/done handshake with
// timeout, result latch and the 24-bit display word.
module fp_operand_sequencer
    import fp_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_OPS   = 2,
    parameter int SW_W    = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn,
    input  logic [SW_W-1:0]        sw,
    output logic [N_OPS*WIDTH-1:0] ops,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [WIDTH-1:0]       alu_result,
    output logic [WIDTH-1:0]       result,
    output logic [1:0]             state,
    output logic [23:0]            visualizar
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned PAGES = WIDTH / 16;
    localparam int unsigned P     = $clog2(PAGES);
    localparam int unsigned PW    = (P > 0) ? P : 1;
    localparam int unsigned BW    = ($clog2(BYTES) > 0) ? $clog2(BYTES) : 1;
    localparam int unsigned OW    = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam int unsigned CW    = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    state_t                 state_q, state_d;
    logic [OW-1:0]          op_idx_q, op_idx_d;
    logic [BW-1:0]          byte_idx_q, byte_idx_d;
    logic [N_OPS*WIDTH-1:0] ops_q, ops_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   start_q, start_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             last_q, last_d;

    logic                   press;
    logic [7:0]             data_byte;
    logic [PW-1:0]          page;
    int unsigned            wr_base;
    int unsigned            show_base;
    logic                   unused_sw;

    btn_edge_sync u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    assign data_byte = sw[SW_W-1 -: 8];
    assign page      = (P == 0) ? '0 : sw[PW-1:0];
    assign unused_sw = ^sw;

    always_comb begin
        state_d    = state_q;
        op_idx_d   = op_idx_q;
        byte_idx_d = byte_idx_q;
        ops_d      = ops_q;
        result_d   = result_q;
        start_d    = 1'b0;
        cnt_d      = cnt_q;
        last_d     = last_q;
        // Entry is MSB first: byte 0 of an operand lands in its top byte lane.
        wr_base    = 32'(op_idx_q) * WIDTH + (BYTES - 1 - 32'(byte_idx_q)) * 8;

        case (state_q)
            ENTRY: begin
                if (press) begin
                    ops_d[wr_base +: 8] = data_byte;
                    last_d              = data_byte;
                    if (byte_idx_q == BW'(BYTES - 1)) begin
                        byte_idx_d = '0;
                        if (op_idx_q == OW'(N_OPS - 1)) begin
                            op_idx_d = '0;
                            state_d  = CALC;
                            start_d  = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            op_idx_d = op_idx_q + OW'(1);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                    end
                end
            end
            CALC: begin
                // done wins over timeout, including on the start cycle itself
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = SHOW;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHOW, ERR: begin
                if (press) begin
                    state_d    = ENTRY;
                    op_idx_d   = '0;
                    byte_idx_d = '0;
                    last_d     = '0;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ENTRY;
            op_idx_q   <= '0;
            byte_idx_q <= '0;
            ops_q      <= '0;
            result_q   <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_idx_q   <= op_idx_d;
            byte_idx_q <= byte_idx_d;
            ops_q      <= ops_d;
            result_q   <= result_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    // Page 0 is the most significant half-word so the result reads MSB first.
    assign show_base = (PAGES - 1 - 32'(page)) * 16;

    always_comb begin
        case (state_q)
            ENTRY:   visualizar = {ST_OP_BASE + 4'(op_idx_q), 4'(byte_idx_q) + 4'd1,
                                   data_byte, last_q};
            CALC:    visualizar = {ST_CALC, 16'h0000};
            SHOW:    visualizar = {ST_SHOW_HI, 4'(page), result_q[show_base +: 16]};
            default: visualizar = {ST_ERR, 16'hEEEE};
        endcase
    end

    assign ops       = ops_q;
    assign result    = result_q;
    assign alu_start = start_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// Self-checking bench: 32-bit/2-operand and 64-bit/1-operand instances.
module tb_fp_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn, btn64;
    logic [9:0]  sw, sw64;
    logic        done_r, tie;
    logic [31:0] res32;
    logic [63:0] res64;

    logic [63:0] ops32;
    logic        start32, done32;
    logic [31:0] result32;
    logic [1:0]  st32;
    logic [23:0] vis32;

    logic [63:0] ops64;
    logic        start64, done64;
    logic [63:0] result64;
    logic [1:0]  st64;
    logic [23:0] vis64;

    int checks = 0;
    int errors = 0;
    int starts32 = 0;

    assign done32 = tie ? start32 : done_r;
    assign done64 = start64;

    fp_operand_sequencer #(.WIDTH(32), .N_OPS(2), .SW_W(10), .TIMEOUT(16)) dut32 (
        .clk(clk), .reset(reset), .btn(btn), .sw(sw), .ops(ops32),
        .alu_start(start32), .alu_done(done32), .alu_result(res32),
        .result(result32), .state(st32), .visualizar(vis32)
    );

    fp_operand_sequencer #(.WIDTH(64), .N_OPS(1), .SW_W(10), .TIMEOUT(16)) dut64 (
        .clk(clk), .reset(reset), .btn(btn64), .sw(sw64), .ops(ops64),
        .alu_start(start64), .alu_done(done64), .alu_result(res64),
        .result(result64), .state(st64), .visualizar(vis64)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start32) starts32++;

    typedef struct {
        logic [63:0] bytes;
        logic [31:0] res;
        logic [63:0] exp_ops;
        logic [23:0] exp_vis0;
        logic [23:0] exp_vis1;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_press(input bit w, input logic [7:0] b, input int hold);
        if (w) begin sw64[9:2] = b; btn64 = 1'b1; end
        else begin sw[9:2] = b; btn = 1'b1; end
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        btn64 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Leaves the button held; returns at the negedge of the start cycle.
    task automatic final_press(input bit w, input logic [7:0] b, output int cyc);
        if (w) begin sw64[9:2] = b; btn64 = 1'b1; end
        else begin sw[9:2] = b; btn = 1'b1; end
        cyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((w ? start64 : start32) === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check("start_latency", 64'(cyc), 64'd2);
        check("calc_vis", 64'(w ? vis64 : vis32), 64'h00CC0000);
    endtask

    task automatic enter(input bit w, input logic [63:0] bytes);
        int bpo;
        int cyc;
        logic [7:0] b;
        logic [7:0] last;
        bpo = w ? 8 : 4;
        last = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = bytes[63 - 8*i -: 8];
            if (w) sw64[9:2] = b; else sw[9:2] = b;
            #1;
            check("entry_vis", 64'(w ? vis64 : vis32),
                  64'({8'(8'hA1 + 16*(i/bpo) + i%bpo), b, last}));
            last = b;
            if (i < 7) begin
                done_r = 1'($urandom);
                do_press(w, b, $urandom_range(1, 4));
            end else begin
                done_r = 1'b0;
                final_press(w, b, cyc);
            end
        end
    endtask

    // Entered at the negedge of CALC cycle 0; d<0 means no done at all.
    task automatic calc32(input int d);
        int n;
        if (d == 0) begin
            tie = 1'b1;
            @(negedge clk);
            tie = 1'b0;
        end else if (d > 0) begin
            repeat (d) @(negedge clk);
            check("calc_wait_state", 64'(st32), 64'd1);
            done_r = 1'b1;
            @(negedge clk);
            done_r = 1'b0;
        end else begin
            n = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (st32 != 2'd1) break;
                n++;
            end
            check("timeout_cycles", 64'(n), 64'd16);
        end
    endtask

    task automatic back_to_entry(input bit w);
        btn = 1'b0;
        btn64 = 1'b0;
        repeat (4) @(negedge clk);
        do_press(w, 8'h3C, 2);
        check("return_state", 64'(w ? st64 : st32), 64'd0);
        check("return_vis", 64'(w ? vis64 : vis32), 64'({8'hA1, 8'h3C, 8'h00}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_res;
        logic [31:0] eo0, eo1;
        logic [63:0] rb;
        int d;
        int s0;
        int pg;

        tbl[0] = '{64'hAABBCCDD11223344, 32'hC1A00000, 64'h11223344AABBCCDD, 24'h50C1A0, 24'h510000};
        tbl[1] = '{64'h01020304FFFEFDFC, 32'h3F801234, 64'hFFFEFDFC01020304, 24'h503F80, 24'h511234};
        tbl[2] = '{64'h0000000080000001, 32'hDEADBEEF, 64'h8000000100000000, 24'h50DEAD, 24'h51BEEF};

        btn = 1'b0; btn64 = 1'b0; done_r = 1'b0; tie = 1'b0;
        sw = 10'h2A4; sw64 = 10'h000; res32 = '0; res64 = '0;
        reset = 1'b1;
        #1;
        check("reset_state", 64'(st32), 64'd0);
        check("reset_ops", ops32, 64'd0);
        check("reset_result", 64'(result32), 64'd0);
        check("reset_start", 64'(start32), 64'd0);
        check("reset_vis", 64'(vis32), 64'({8'hA1, 8'hA9, 8'h00}));
        check("reset_vis64", 64'(vis64), 64'h00A10000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Press latency and held button, with alu_done high outside CALC
        done_r = 1'b1;
        sw[9:2] = 8'h5A;
        btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("latency_before", 64'(vis32[7:0]), 64'h00);
        @(negedge clk);
        check("latency_capture", 64'(vis32[7:0]), 64'h5A);
        repeat (47) @(negedge clk);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        check("held_once", 64'(vis32[23:16]), 64'hA2);
        check("done_ignored_state", 64'(st32), 64'd0);
        check("done_ignored_result", 64'(result32), 64'd0);
        done_r = 1'b0;

        // Reset mid-entry
        do_press(1'b0, 8'h66, 1);
        do_press(1'b0, 8'h77, 3);
        check("pre_reset_ops", ops32, 64'h5A667700);
        reset = 1'b1;
        #1;
        check("mid_reset_state", 64'(st32), 64'd0);
        check("mid_reset_ops", ops32, 64'd0);
        check("mid_reset_vis", 64'(vis32), 64'({8'hA1, sw[9:2], 8'h00}));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_press(1'b0, 8'h99, 2);
        check("post_reset_ops", ops32, 64'h99000000);
        check("post_reset_vis", 64'(vis32[23:16]), 64'hA2);

        // Table vectors with done tied to start
        do_reset();
        for (int e = 0; e < 3; e++) begin
            res32 = tbl[e].res;
            s0 = starts32;
            enter(1'b0, tbl[e].bytes);
            calc32(0);
            check("tbl_state", 64'(st32), 64'd2);
            check("tbl_ops", ops32, tbl[e].exp_ops);
            check("tbl_starts", 64'(starts32 - s0), 64'd1);
            sw[0] = 1'b0;
            #1;
            check("tbl_page0", 64'(vis32), 64'(tbl[e].exp_vis0));
            sw[0] = 1'b1;
            #1;
            check("tbl_page1", 64'(vis32), 64'(tbl[e].exp_vis1));
            sw[0] = 1'b0;
            back_to_entry(1'b0);
        end

        // Timeout keeps the previous result
        res32 = 32'h55555555;
        enter(1'b0, 64'h0123456789ABCDEF);
        calc32(-1);
        check("timeout_state", 64'(st32), 64'd3);
        check("timeout_vis", 64'(vis32), 64'h00EEEEEE);
        check("timeout_result", 64'(result32), 64'hDEADBEEF);
        back_to_entry(1'b0);

        // Press during CALC (dc=5) and on the CALC->SHOW edge (dc=3)
        for (int k = 0; k < 2; k++) begin
            int dc;
            dc = (k == 0) ? 5 : 3;
            res32 = 32'h12345600 + 32'(dc);
            enter(1'b0, 64'h1020304050607080);
            btn = 1'b0;
            @(negedge clk);
            btn = 1'b1;
            repeat (dc - 1) @(negedge clk);
            done_r = 1'b1;
            @(negedge clk);
            done_r = 1'b0;
            check("ign_state", 64'(st32), 64'd2);
            check("ign_result", 64'(result32), 64'(32'h12345600 + 32'(dc)));
            repeat (6) @(negedge clk);
            check("ign_still_show", 64'(st32), 64'd2);
            back_to_entry(1'b0);
        end

        // Randomised transactions against a queue-of-bytes model
        do_reset();
        exp_res = '0;
        for (int t = 0; t < 12; t++) begin
            rb = {$urandom, $urandom};
            eo0 = '0;
            eo1 = '0;
            for (int i = 0; i < 8; i++) begin
                if (i < 4) eo0 = (eo0 << 8) | 32'(rb[63 - 8*i -: 8]);
                else       eo1 = (eo1 << 8) | 32'(rb[63 - 8*i -: 8]);
            end
            d = $urandom_range(0, 19);
            if (d == 15) d = 16;
            if (d >= 16) d = -1;
            res32 = $urandom;
            s0 = starts32;
            enter(1'b0, rb);
            calc32(d);
            if (d >= 0) exp_res = res32;
            check("rnd_ops", ops32, {eo1, eo0});
            check("rnd_state", 64'(st32), (d >= 0) ? 64'd2 : 64'd3);
            check("rnd_result", 64'(result32), 64'(exp_res));
            check("rnd_starts", 64'(starts32 - s0), 64'd1);
            pg = $urandom_range(0, 1);
            sw[0] = 1'(pg);
            #1;
            if (d >= 0)
                check("rnd_vis", 64'(vis32),
                      64'({4'h5, 4'(pg), (pg == 1) ? exp_res[15:0] : exp_res[31:16]}));
            else
                check("rnd_vis", 64'(vis32), 64'h00EEEEEE);
            back_to_entry(1'b0);
        end

        // 64-bit configuration, one operand
        do_reset();
        res64 = 64'hFEDCBA9876543210;
        enter(1'b1, 64'h0102030405060708);
        @(negedge clk);
        check("w64_state", 64'(st64), 64'd2);
        check("w64_ops", ops64, 64'h0102030405060708);
        check("w64_result", result64, 64'hFEDCBA9876543210);
        for (int p = 0; p < 4; p++) begin
            sw64[1:0] = 2'(p);
            #1;
            check("w64_page", 64'(vis64), 64'({4'h5, 4'(p), res64[63 - 16*p -: 16]}));
        end
        back_to_entry(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
